// File: rtl/enable_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | enable_sched: periodic tick generator with 4-way round-robin slot grant  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module enable_sched #(
  parameter int PERIOD = 10,
  parameter int WIDTH  = 4
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic [3:0] i_req,
  output logic       o_tick,
  output logic [3:0] o_grant,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(PERIOD - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [1:0]       last;
  logic [1:0]       last_nxt;
  logic             tick_nxt;
  logic [3:0]       grant_nxt;
  logic             wrap;
  logic             rr_hit;
  logic [1:0]       rr_idx;
  logic [1:0]       rr_probe;
  logic [3:0]       rr_grant;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    rr_hit   = 1'b0;
    rr_idx   = last;
    rr_probe = last;
    for (int k = 1; k <= 4; k++) begin
      rr_probe = last + 2'(k);
      if (!rr_hit && i_req[rr_probe]) begin
        rr_hit = 1'b1;
        rr_idx = rr_probe;
      end
    end
    rr_grant = rr_hit ? (4'b0001 << rr_idx) : 4'b0000;
  end

  assign wrap = (state != IDLE) && (cnt == CNT_MAX);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    tick_nxt  = 1'b0;
    grant_nxt = 4'b0000;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (i_run) state_nxt = RUN;
      end
      RUN, DRAIN: begin
        if (wrap) begin
          tick_nxt  = 1'b1;
          grant_nxt = rr_grant;
          cnt_nxt   = '0;
          if (rr_hit) last_nxt = rr_idx;
          state_nxt = i_run ? RUN : IDLE;
        end else begin
          cnt_nxt   = cnt + WIDTH'(1);
          state_nxt = i_run ? RUN : DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 2'd3;
      o_tick  <= 1'b0;
      o_grant <= 4'b0000;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      o_tick  <= tick_nxt;
      o_grant <= grant_nxt;
      o_busy  <= (state_nxt != IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enable_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_enable_sched: self-checking bench for enable_sched (PERIOD=4)         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_enable_sched;

  localparam int PERIOD = 4;
  localparam int WIDTH  = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       run   = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic       o_tick;
  logic [3:0] o_grant;
  logic       o_busy;

  int checks = 0;
  int passes = 0;

  // Reference model: "active" session with a phase counter; RUN/DRAIN merged.
  bit         m_active;
  int         m_phase;
  int         m_last;
  logic       exp_tick;
  logic [3:0] exp_grant;
  logic       exp_busy;

  enable_sched #(.PERIOD(PERIOD), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_run   (run),
    .i_req   (req),
    .o_tick  (o_tick),
    .o_grant (o_grant),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active  = 1'b0;
    m_phase   = 0;
    m_last    = 3;
    exp_tick  = 1'b0;
    exp_grant = 4'b0000;
    exp_busy  = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] q);
    int found;
    exp_tick  = 1'b0;
    exp_grant = 4'b0000;
    if (!m_active) begin
      if (r) begin
        m_active = 1'b1;
        m_phase  = 0;
      end
    end else if (m_phase == PERIOD - 1) begin
      exp_tick = 1'b1;
      m_phase  = 0;
      found    = -1;
      for (int k = 1; k <= 4; k++) begin
        if (found < 0 && q[(m_last + k) % 4]) found = (m_last + k) % 4;
      end
      if (found >= 0) begin
        exp_grant = 4'(1 << found);
        m_last    = found;
      end
      if (!r) m_active = 1'b0;
    end else begin
      m_phase++;
    end
    exp_busy = m_active;
  endtask

  task automatic step(input logic r, input logic [3:0] q);
    @(negedge clk);
    run = r;
    req = q;
    @(posedge clk);
    model_edge(r, q);
    #1;
  endtask

  task automatic test_reset();
    run = 1'b1;
    req = 4'b1111;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({o_tick, o_grant, o_busy} !== 6'b0)
      $display("FAIL reset_async: got tick=%b grant=%b busy=%b, want all 0", o_tick, o_grant, o_busy);
    else passes++;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if ({o_tick, o_grant, o_busy} !== 6'b0)
        $display("FAIL reset_hold: got tick=%b grant=%b busy=%b, want all 0", o_tick, o_grant, o_busy);
      else passes++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b0;
    @(posedge clk);
    model_edge(1'b0, req);
    #1;
    checks++;
    if ({o_tick, o_grant, o_busy} !== {exp_tick, exp_grant, exp_busy})
      $display("FAIL release_idle: got tick=%b grant=%b busy=%b, want tick=%b grant=%b busy=%b",
               o_tick, o_grant, o_busy, exp_tick, exp_grant, exp_busy);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [3:0] gq[$];
    logic [3:0] want[5];
    logic [3:0] got;
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 21; i++) begin
      step(1'b1, 4'b1111);
      checks++;
      if ({o_tick, o_grant, o_busy} !== {exp_tick, exp_grant, exp_busy})
        $display("FAIL rr_model cyc %0d: got tick=%b grant=%b busy=%b, want tick=%b grant=%b busy=%b",
                 i, o_tick, o_grant, o_busy, exp_tick, exp_grant, exp_busy);
      else passes++;
      if (o_tick === 1'b1) gq.push_back(o_grant);
    end
    for (int i = 0; i < 5; i++) begin
      got = (i < gq.size()) ? gq[i] : 4'bxxxx;
      checks++;
      if (got !== want[i])
        $display("FAIL rr_order #%0d: got grant=%b, want %b", i, got, want[i]);
      else passes++;
    end
  endtask

  task automatic test_alternate();
    logic [3:0] prev;
    bit         first;
    first = 1'b1;
    prev  = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'b0101);
      checks++;
      if ({o_tick, o_grant, o_busy} !== {exp_tick, exp_grant, exp_busy})
        $display("FAIL alt_model cyc %0d: got tick=%b grant=%b busy=%b, want tick=%b grant=%b busy=%b",
                 i, o_tick, o_grant, o_busy, exp_tick, exp_grant, exp_busy);
      else passes++;
      if (o_tick === 1'b1) begin
        checks++;
        if (!((o_grant === 4'b0001 || o_grant === 4'b0100) && (first || o_grant !== prev)))
          $display("FAIL alt_order: got grant=%b after %b, want alternating 0001/0100", o_grant, prev);
        else passes++;
        prev  = o_grant;
        first = 1'b0;
      end
    end
  endtask

  task automatic test_no_req();
    logic [3:0] g[3];
    logic [3:0] q;
    int         nt;
    nt = 0;
    g  = '{4'bxxxx, 4'bxxxx, 4'bxxxx};
    for (int i = 0; i < 16 && nt < 3; i++) begin
      q = (nt == 0) ? 4'b0010 : (nt == 1) ? 4'b0000 : 4'b1111;
      step(1'b1, q);
      checks++;
      if ({o_tick, o_grant, o_busy} !== {exp_tick, exp_grant, exp_busy})
        $display("FAIL noreq_model cyc %0d: got tick=%b grant=%b busy=%b, want tick=%b grant=%b busy=%b",
                 i, o_tick, o_grant, o_busy, exp_tick, exp_grant, exp_busy);
      else passes++;
      if (o_tick === 1'b1) begin
        g[nt] = o_grant;
        nt++;
      end
    end
    checks++;
    if (nt != 3 || g[0] !== 4'b0010 || g[1] !== 4'b0000 || g[2] !== 4'b0100)
      $display("FAIL noreq_seq: got %0d ticks grants %b %b %b, want 3 ticks 0010 0000 0100",
               nt, g[0], g[1], g[2]);
    else passes++;
  endtask

  task automatic test_drain();
    logic r;
    logic want_tick;
    logic want_busy;
    for (int j = 1; j <= 25; j++) begin
      r = !((j >= 2 && j <= 12) || j == 19);
      step(r, 4'b1111);
      want_tick = (j == 4 || j == 17 || j == 21 || j == 25);
      want_busy = (j <= 3) || (j >= 13);
      checks++;
      if ({o_tick, o_grant, o_busy} !== {exp_tick, exp_grant, exp_busy})
        $display("FAIL drain_model j=%0d: got tick=%b grant=%b busy=%b, want tick=%b grant=%b busy=%b",
                 j, o_tick, o_grant, o_busy, exp_tick, exp_grant, exp_busy);
      else passes++;
      checks++;
      if (o_tick !== want_tick || o_busy !== want_busy)
        $display("FAIL drain_seq j=%0d: got tick=%b busy=%b, want tick=%b busy=%b",
                 j, o_tick, o_busy, want_tick, want_busy);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 2; k++) step(1'b1, 4'b1111);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({o_tick, o_grant, o_busy} !== 6'b0)
      $display("FAIL reset_mid_async: got tick=%b grant=%b busy=%b, want all 0", o_tick, o_grant, o_busy);
    else passes++;
    #1 rst_n = 1'b1;
    for (int k = 3; k <= 8; k++) begin
      step(1'b1, 4'b1111);
      checks++;
      if (o_tick !== (k == 7) || (k == 7 && o_grant !== 4'b0001))
        $display("FAIL reset_mid_seq k=%0d: got tick=%b grant=%b, want tick=%b grant=%b",
                 k, o_tick, o_grant, (k == 7), (k == 7) ? 4'b0001 : 4'b0000);
      else passes++;
      checks++;
      if ({o_tick, o_grant, o_busy} !== {exp_tick, exp_grant, exp_busy})
        $display("FAIL reset_mid_model k=%0d: got tick=%b grant=%b busy=%b, want tick=%b grant=%b busy=%b",
                 k, o_tick, o_grant, o_busy, exp_tick, exp_grant, exp_busy);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic       r;
    logic [3:0] q;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 3) != 0);
      q = 4'($urandom);
      step(r, q);
      checks++;
      if ({o_tick, o_grant, o_busy} !== {exp_tick, exp_grant, exp_busy})
        $display("FAIL rand_model cyc %0d: got tick=%b grant=%b busy=%b, want tick=%b grant=%b busy=%b",
                 i, o_tick, o_grant, o_busy, exp_tick, exp_grant, exp_busy);
      else passes++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_alternate();
    test_no_req();
    test_drain();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enable_sched.md
ENABLE_SCHED -- requirements
Module: enable_sched

Interface
REQ-001 Parameter PERIOD, default 10: tick period in clock cycles; legal range 2..2**WIDTH.
REQ-002 Parameter WIDTH, default 4: width of the internal period counter.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port i_run, input, 1: level run request; 1 = generate ticks, 0 = stop after the current period.
REQ-006 Port i_req, input, 4: per-requester level requests for a tick slot.
REQ-007 Port o_tick, output, 1: registered one-cycle pulse, once per PERIOD cycles while active.
REQ-008 Port o_grant, output, 4: registered one-hot grant, high only in o_tick cycles; all zero otherwise.
REQ-009 Port o_busy, output, 1: registered; high whenever state is not IDLE.

Function
REQ-010 The block SHALL contain a state machine with states IDLE, RUN and DRAIN.
REQ-011 Counter cnt (WIDTH bits) SHALL be held at 0 in IDLE and count 0..PERIOD-1, wrapping to 0, in RUN and DRAIN.
REQ-012 IDLE -> RUN SHALL occur on the edge sampling i_run=1; cnt stays 0 on that edge.
REQ-013 RUN -> DRAIN SHALL occur on any edge sampling i_run=0 where cnt != PERIOD-1; cnt continues counting.
REQ-014 DRAIN -> RUN SHALL occur on an edge sampling i_run=1; cnt is not reset; no tick is lost or duplicated.
REQ-015 On the wrap edge (cnt == PERIOD-1, state RUN or DRAIN): o_tick <= 1 and cnt <= 0; the next state is RUN if i_run=1, else IDLE.
REQ-016 On all other edges, o_tick <= 0 and o_grant <= 0.
REQ-017 With i_run held at 1, the first o_tick SHALL be high in the cycle after the PERIOD-th edge following the IDLE->RUN edge; later ticks follow every PERIOD cycles.
REQ-018 On each wrap edge, o_grant SHALL be computed from i_req sampled on that edge: round-robin, searching from index (last+1) mod 4 upward and wrapping.
REQ-019 Pointer last (2 bits) SHALL update to the granted index only when a grant is issued.
REQ-020 If i_req=0 on a wrap edge, o_tick SHALL still pulse, o_grant SHALL be 0 and last SHALL be unchanged.
REQ-021 i_req changes between wrap edges SHALL have no effect; requesters hold req until granted (no internal request latching).
REQ-022 Exactly one o_grant bit SHALL be high in any grant cycle; a grant SHALL never be issued without o_tick.
REQ-023 o_busy SHALL be 1 in RUN and DRAIN; it SHALL fall on the edge entering IDLE, coincident with the final o_tick pulse.

Reset
REQ-024 Asserting i_rst_n=0 SHALL, immediately and independent of clk, force state=IDLE, cnt=0, last=3, o_tick=0, o_grant=0, o_busy=0.
REQ-025 After reset, requester 0 SHALL have highest priority for the first grant.
REQ-026 Reset asserted mid-period SHALL abandon the period with no further tick; operation restarts per REQ-012 after release.

Verification (PERIOD=4, WIDTH=3)
REQ-027 Assert i_rst_n=0 with i_run=1 and i_req=4'b1111 -> o_tick=0, o_grant=0, o_busy=0 asynchronously; outputs stay 0 while reset is held.
REQ-028 Release reset, hold i_run=1 and i_req=4'b1111 -> o_tick pulses every 4 cycles with grants 0001, 0010, 0100, 1000, 0001.
REQ-029 Hold i_req=4'b0101 -> grants alternate 0001, 0100; bits 1 and 3 are never granted.
REQ-030 Drive i_req=0 for one tick, then 4'b1111 after a grant to index 1 -> tick with o_grant=0, then the next grant is 0100.
REQ-031 Drop i_run at cnt=1 -> one more tick at the wrap, o_busy falls with it, then no ticks; re-raise i_run during DRAIN -> ticks continue with no gap or shift.
REQ-032 Pulse i_rst_n low at cnt=2 in RUN -> no tick at the expected wrap; grant order restarts at 0001.
